// File: rtl/unit_square_seq_if.sv
// Operand/result handshake bundle for the sequential squarer.
// The producer/consumer side uses master; the squarer uses slave.
interface unit_square_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [16:0] f_in;
   logic        out_valid;
   logic        out_ready;
   logic [30:0] e_out;
   logic        sat;

   modport master (
      output in_valid, f_in, out_ready,
      input  in_ready, out_valid, e_out, sat
   );

   modport slave (
      input  in_valid, f_in, out_ready,
      output in_ready, out_valid, e_out, sat
   );
endinterface

// File: rtl/unit_square_seq.sv
// Sequential UQ4.13 squarer producing UQ5.26 (e = f*f) by radix-2 shift-add,
// saturating to full scale when the exact UQ8.26 product overflows 31 bits.
module unit_square_seq (
   input  logic               clk,
   input  logic               reset,
   unit_square_seq_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, MUL, FMT, DONE} state_t;

   state_t      state_reg,  state_next;
   logic [33:0] acc_reg,    acc_next;
   logic [33:0] mcand_reg,  mcand_next;
   logic [16:0] mplier_reg, mplier_next;
   logic [4:0]  cnt_reg,    cnt_next;
   logic [30:0] e_reg,      e_next;
   logic        sat_reg,    sat_next;

   // Multiplicand is pre-shifted each cycle, so the current partial product
   // is simply the multiplicand gated by the multiplier's low bit.
   logic [33:0] addend;
   genvar gi;
   generate
      for (gi = 0; gi < 34; gi++) begin : g_addend
         assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
         e_reg      <= '0;
         sat_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         cnt_reg    <= cnt_next;
         e_reg      <= e_next;
         sat_reg    <= sat_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      cnt_next    = cnt_reg;
      e_next      = e_reg;
      sat_next    = sat_reg;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               mcand_next  = {17'b0, bus.f_in};
               mplier_next = bus.f_in;
               acc_next    = '0;
               cnt_next    = '0;
               state_next  = MUL;
            end
         end
         MUL: begin
            acc_next    = acc_reg + addend;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + 5'd1;
            if (cnt_reg == 5'd16) begin
               state_next = FMT;
            end
         end
         FMT: begin
            // Any integer bit above UQ5 means the square left the e range.
            if (|acc_reg[33:31]) begin
               e_next   = 31'h7FFF_FFFF;
               sat_next = 1'b1;
            end else begin
               e_next   = acc_reg[30:0];
               sat_next = 1'b0;
            end
            state_next = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_reg == IDLE) && !reset;
   assign bus.out_valid = (state_reg == DONE);
   assign bus.e_out     = e_reg;
   assign bus.sat       = sat_reg;
endmodule

// File: tb/tb_unit_square_seq.sv
// Scoreboard bench for unit_square_seq: directed boundary values, backpressure,
// mid-operation reset, random operands and an isqrt round trip.
module tb_unit_square_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   unit_square_seq_if bus ();

   unit_square_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [30:0] e_exp;
      logic        sat_exp;
      logic        rt;
      logic [30:0] e_orig;
      logic [16:0] f;
   } sb_t;

   sb_t    sb[$];
   int     pass_cnt = 0;
   int     check_cnt = 0;
   int     xfer_cnt = 0;
   int     push_cnt = 0;
   longint cyc = 0;
   longint acc_cyc = 0;
   logic   ov_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      check_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic void sq_model(input logic [16:0] f, output logic [30:0] e, output logic s);
      longint p;
      p = longint'(f) * longint'(f);
      if (p > 64'h7FFF_FFFF) begin
         e = 31'h7FFF_FFFF;
         s = 1'b1;
      end else begin
         e = p[30:0];
         s = 1'b0;
      end
   endfunction

   function automatic logic [16:0] isqrt(input logic [30:0] e);
      longint r = 0;
      longint t;
      for (int b = 16; b >= 0; b--) begin
         t = r | (longint'(1) << b);
         if (t * t <= longint'(e)) r = t;
      end
      return r[16:0];
   endfunction

   // Pop and compare on every transfer (out_valid && out_ready before the edge).
   always @(negedge clk) begin
      sb_t x;
      if (!reset) begin
         if (bus.out_valid && !ov_prev) check("latency", cyc - acc_cyc, 18);
         if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
            check("ready_valid_excl", bus.in_ready, 0);
            if (sb.size() > 0) begin
               x = sb.pop_front();
               check("e_out", bus.e_out, x.e_exp);
               check("sat", bus.sat, x.sat_exp);
               if (x.rt) begin
                  check("rt_bound",
                        ((longint'(x.e_orig) - longint'(bus.e_out) >= 0) &&
                         (longint'(x.e_orig) - longint'(bus.e_out) <= 2 * longint'(x.f))) ? 1 : 0, 1);
               end
            end
            xfer_cnt++;
         end
      end
      ov_prev = bus.out_valid;
   end

   task automatic send(input logic [16:0] f, input bit push, input bit rt,
                       input logic [30:0] e_orig, output int waited);
      logic [30:0] e;
      logic        s;
      waited = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", 0, 1);
         return;
      end
      bus.in_valid = 1'b1;
      bus.f_in     = f;
      if (push) begin
         sq_model(f, e, s);
         sb.push_back('{e, s, rt, e_orig, f});
         push_cnt++;
      end
      @(posedge clk);
      #1;
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
      bus.f_in     = 17'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask

   logic [16:0] dir_f [5] = '{17'h00000, 17'h02000, 17'h0B504, 17'h0B505, 17'h1FFFF};
   logic [30:0] dir_e [5] = '{31'h0000000, 31'h4000000, 31'h7FFEA810, 31'h7FFFFFFF, 31'h7FFFFFFF};
   logic        dir_s [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int          w;
      logic [30:0] e_tmp;
      logic        s_tmp;
      logic        seen;
      logic [30:0] e_rand;

      bus.in_valid  = 1'b0;
      bus.f_in      = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready_low", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_e_out", bus.e_out, 0);
      check("rst_sat", bus.sat, 0);

      // Directed values: confirm the model agrees with the known constants.
      for (int i = 0; i < 5; i++) begin
         sq_model(dir_f[i], e_tmp, s_tmp);
         check("dir_model_e", e_tmp, dir_e[i]);
         check("dir_model_sat", s_tmp, dir_s[i]);
         send(dir_f[i], 1'b1, 1'b0, '0, w);
      end
      drain();

      // Backpressure for 10 cycles with a stray in_valid that must be ignored.
      bus.out_ready = 1'b0;
      send(17'h02D41, 1'b1, 1'b0, '0, w);
      w = 0;
      while (!bus.out_valid && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("bp_valid_rise", bus.out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid_held", bus.out_valid, 1);
         check("bp_e_stable", bus.e_out, 31'h7FFEA81);
         check("bp_in_ready", bus.in_ready, 0);
         bus.in_valid = 1'b1;
         bus.f_in     = 17'h1FFFF;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_valid_fall", bus.out_valid, 0);
      check("bp_ready_back", bus.in_ready, 1);
      send(17'h02000, 1'b1, 1'b0, '0, w);
      check("bp_next_accept_wait", w, 0);
      drain();

      // Reset in the middle of MUL discards the operation.
      send(17'h1FFFF, 1'b0, 1'b0, '0, w);
      repeat (8) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("abort_in_ready_low", bus.in_ready, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_in_ready", bus.in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         seen |= bus.out_valid;
         @(negedge clk);
      end
      check("abort_no_valid", seen, 0);
      send(17'h02000, 1'b1, 1'b0, '0, w);
      drain();

      // Random operands, exact model.
      for (int i = 0; i < 20; i++) begin
         send(17'($urandom_range(0, 17'h1FFFF)), 1'b1, 1'b0, '0, w);
      end
      drain();

      // Round trip e -> isqrt -> square, e' within 2f of e and never saturated.
      for (int i = 0; i < 20; i++) begin
         e_rand = 31'($urandom);
         send(isqrt(e_rand), 1'b1, 1'b1, e_rand, w);
      end
      drain();

      check("xfer_count", xfer_cnt, push_cnt);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
